// File: rtl/wb_sram_slave_if.sv
// Wishbone classic byte bus between a master and wb_sram_slave.
// With WB_SRAM_ERR_EN defined the bus also carries the out-of-range error line.
interface wb_sram_slave_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [23:0] wb_adr_i;
    logic        wb_we_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;
`ifdef WB_SRAM_ERR_EN
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
`else
    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
`endif
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic byte slave driving an asynchronous video SRAM with a fixed access time.
// Optional WB_SRAM_ERR_EN: out-of-range transfers end with wb_err_o instead of wb_ack_o.
module wb_sram_slave #(
    parameter int SRAM_AW     = 19,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_sram_slave_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [7:0]         sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       we_q;
    logic       wr_abort;
    logic       in_range;

    // Upper address bits only feed the range check, so no aliasing into the SRAM window.
    assign in_range = (bus.wb_adr_i >> SRAM_AW) == 24'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            wr_abort     <= 1'b0;
            sram_addr    <= '0;
            sram_dq_o    <= 8'h00;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= 8'h00;
`ifdef WB_SRAM_ERR_EN
            bus.wb_err_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.wb_ack_o <= 1'b0;
`ifdef WB_SRAM_ERR_EN
                    bus.wb_err_o <= 1'b0;
`endif
                    if (bus.wb_cyc_i && bus.wb_stb_i) begin
                        sram_addr <= bus.wb_adr_i[SRAM_AW-1:0];
                        sram_dq_o <= bus.wb_dat_i;
                        we_q      <= bus.wb_we_i;
                        wr_abort  <= 1'b0;
                        if (in_range) begin
                            state      <= ACCESS;
                            cnt        <= 4'(WAIT_CYCLES - 1);
                            sram_ce_n  <= 1'b0;
                            sram_oe_n  <= bus.wb_we_i;
                            sram_we_n  <= !bus.wb_we_i;
                            sram_dq_oe <= bus.wb_we_i;
                        end else begin
                            state <= DONE;
`ifdef WB_SRAM_ERR_EN
                            bus.wb_err_o <= 1'b1;
`else
                            bus.wb_ack_o <= 1'b1;
                            if (!bus.wb_we_i)
                                bus.wb_dat_o <= 8'hFF;
`endif
                        end
                    end
                end
                ACCESS: begin
                    // A dropped cycle kills a read at once but never truncates a write pulse.
                    if (!we_q && !bus.wb_cyc_i) begin
                        state     <= IDLE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (we_q && (wr_abort || !bus.wb_cyc_i)) begin
                            state      <= IDLE;
                            sram_dq_oe <= 1'b0;
                        end else begin
                            state        <= DONE;
                            bus.wb_ack_o <= 1'b1;
                            if (!we_q)
                                bus.wb_dat_o <= sram_dq_i;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (!bus.wb_cyc_i)
                            wr_abort <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.wb_ack_o <= 1'b0;
                    sram_dq_oe   <= 1'b0;
`ifdef WB_SRAM_ERR_EN
                    bus.wb_err_o <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: directed table, abort/stuck-strobe/reset sequences,
// and random traffic against a byte-array reference of the SRAM contents.
module tb_wb_sram_slave;
    localparam int SRAM_AW = 19;
    localparam int W       = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_sram_slave_if bus();
    logic [SRAM_AW-1:0] sram_addr;
    logic [7:0]         sram_dq_o;
    logic [7:0]         sram_dq_i;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    wb_sram_slave #(.SRAM_AW(SRAM_AW), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    // Asynchronous SRAM device model
    logic [7:0] mem [0:(1<<SRAM_AW)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;
    always @(negedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[sram_addr] <= sram_dq_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [int];
    logic [7:0] prev_dat;

    typedef struct {
        logic [23:0] adr;
        logic        we;
        logic [7:0]  dat;
        int          lat;
        logic [7:0]  rdat;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [23:0] a);
        return a < 24'(1 << SRAM_AW);
    endfunction

    // One stb-pulse transfer with cyc held for a fixed 8-cycle window.
    task automatic xfer(input string tag, input logic [23:0] a, input logic w,
                        input logic [7:0] d, input int exp_lat, input logic [7:0] exp_dat);
        bit         inr = in_rng(a);
        int         nack = 0, nerr = 0, first = 0;
        int         oe_cnt = 0, we_cnt = 0, dqoe_cnt = 0, ce_cnt = 0, bad_hold = 0;
        int         exp_ack = 1, exp_err = 0;
        logic [7:0] rd = 8'h00;
        logic [7:0] exp_rd = exp_dat;
        logic [SRAM_AW-1:0] a_low = a[SRAM_AW-1:0];
`ifdef WB_SRAM_ERR_EN
        if (!inr) begin
            exp_ack = 0;
            exp_err = 1;
            exp_rd  = prev_dat;
        end
`endif
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = a;
        bus.wb_we_i  = w;
        bus.wb_dat_i = d;
        tick();
        bus.wb_stb_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (!sram_ce_n) ce_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (sram_dq_oe) dqoe_cnt++;
            if (sram_dq_oe && sram_dq_o !== d) bad_hold++;
            if (!sram_ce_n && sram_addr !== a_low) bad_hold++;
`ifdef WB_SRAM_ERR_EN
            if (bus.wb_err_o) begin
                nerr++;
                if (first == 0) first = n;
            end
`endif
            if (bus.wb_ack_o) begin
                nack++;
                if (first == 0) begin
                    first = n;
                    rd = bus.wb_dat_o;
                end
            end
            tick();
        end
        bus.wb_cyc_i = 1'b0;
        check({tag, "_ack_count"}, nack, exp_ack);
        check({tag, "_err_count"}, nerr, exp_err);
        check({tag, "_latency"}, first, exp_lat);
        if (!w) begin
            if (exp_ack == 1) check({tag, "_rdata"}, rd, exp_rd);
            else              check({tag, "_rdata_kept"}, bus.wb_dat_o, exp_rd);
        end
        check({tag, "_ce_cycles"}, ce_cnt, inr ? W : 0);
        check({tag, "_oe_cycles"}, oe_cnt, (inr && !w) ? W : 0);
        check({tag, "_we_cycles"}, we_cnt, (inr && w) ? W : 0);
        check({tag, "_dqoe_cycles"}, dqoe_cnt, (inr && w) ? W + 1 : 0);
        check({tag, "_addr_data_hold"}, bad_hold, 0);
        if (w && inr) ref_mem[int'(a)] = d;
        if (!w && exp_ack == 1) prev_dat = exp_rd;
    endtask

    initial begin
        int nack;
        int cnt;
        int last;
        int gapbad;
        int bad;
        logic [23:0] a;
        logic        w;
        logic [7:0]  d;

        rst          = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_adr_i = 24'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_dat_i = 8'h00;
        prev_dat     = 8'h00;

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            mem[i] = d;
            ref_mem[i] = d;
            d = 8'($urandom);
            mem[32'h7FFF0 + i] = d;
            ref_mem[32'h7FFF0 + i] = d;
        end
        mem[24'h001234] = 8'hA5;  ref_mem[32'h1234]  = 8'hA5;
        mem[24'h07FFFF] = 8'h5E;  ref_mem[32'h7FFFF] = 8'h5E;
        mem[24'h000020] = 8'h11;  ref_mem[32'h20]    = 8'h11;

        tbl[0] = '{adr: 24'h001234, we: 1'b0, dat: 8'h00, lat: W + 1, rdat: 8'hA5};
        tbl[1] = '{adr: 24'h000010, we: 1'b1, dat: 8'h3C, lat: W + 1, rdat: 8'h00};
        tbl[2] = '{adr: 24'h000010, we: 1'b0, dat: 8'h00, lat: W + 1, rdat: 8'h3C};
        tbl[3] = '{adr: 24'h080000, we: 1'b0, dat: 8'h00, lat: 1,     rdat: 8'hFF};
        tbl[4] = '{adr: 24'hFFFFFF, we: 1'b1, dat: 8'h99, lat: 1,     rdat: 8'h00};
        tbl[5] = '{adr: 24'h07FFFF, we: 1'b0, dat: 8'h00, lat: W + 1, rdat: 8'h5E};
        tbl[6] = '{adr: 24'h07FFFF, we: 1'b1, dat: 8'h66, lat: W + 1, rdat: 8'h00};
        tbl[7] = '{adr: 24'h07FFFF, we: 1'b0, dat: 8'h00, lat: W + 1, rdat: 8'h66};
        tbl[8] = '{adr: 24'h080010, we: 1'b1, dat: 8'hEE, lat: 1,     rdat: 8'h00};
        tbl[9] = '{adr: 24'h000010, we: 1'b0, dat: 8'h00, lat: W + 1, rdat: 8'h3C};

        tick();
        tick();
        check("reset_ack", bus.wb_ack_o, 0);
        check("reset_dat", bus.wb_dat_o, 8'h00);
        check("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("reset_dq_oe", sram_dq_oe, 0);
        check("reset_addr", sram_addr, 0);
        check("reset_dq_o", sram_dq_o, 8'h00);
`ifdef WB_SRAM_ERR_EN
        check("reset_err", bus.wb_err_o, 0);
`endif
        rst = 1'b0;
        tick();

        foreach (tbl[i])
            xfer($sformatf("vec%0d", i), tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].lat, tbl[i].rdat);

        // Read abort: cyc drops one cycle into the access
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 24'h001234; bus.wb_we_i = 1'b0;
        tick();
        bus.wb_stb_i = 1'b0;
        check("abort_rd_oe_active", sram_oe_n, 0);
        bus.wb_cyc_i = 1'b0;
        tick();
        check("abort_rd_released", {sram_ce_n, sram_oe_n}, 2'b11);
        nack = 0;
        for (int n = 0; n < 5; n++) begin
            if (bus.wb_ack_o) nack++;
            tick();
        end
        check("abort_rd_no_ack", nack, 0);

        // Write abort: pulse must run its full length
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 24'h000020;
        bus.wb_we_i = 1'b1; bus.wb_dat_i = 8'h5A;
        tick();
        bus.wb_stb_i = 1'b0;
        cnt = 0; nack = 0;
        if (!sram_we_n) cnt++;
        bus.wb_cyc_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (!sram_we_n) cnt++;
            if (bus.wb_ack_o) nack++;
        end
        check("abort_wr_we_cycles", cnt, W);
        check("abort_wr_no_ack", nack, 0);
        check("abort_wr_mem", mem[24'h000020], 8'h5A);
        ref_mem[32'h20] = 8'h5A;
        xfer("abort_wr_readback", 24'h000020, 1'b0, 8'h00, W + 1, 8'h5A);

        // Stuck strobe: cyc and stb held high
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 24'h001234; bus.wb_we_i = 1'b0;
        nack = 0; last = -1; gapbad = 0; bad = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (bus.wb_ack_o) begin
                nack++;
                if (last >= 0 && n - last != W + 2) gapbad++;
                last = n;
                if (bus.wb_dat_o !== 8'hA5) bad++;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (4) tick();
        check("stuck_ack_count", nack, 4);
        check("stuck_ack_spacing", gapbad, 0);
        check("stuck_rdata", bad, 0);
        prev_dat = 8'hA5;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = ($urandom_range(0, 1) == 0) ? 24'hFFFFFF : 24'h080000 + 24'($urandom_range(0, 15));
                1, 2:    a = 24'h07FFF0 + 24'($urandom_range(0, 15));
                default: a = 24'($urandom_range(0, 15));
            endcase
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            xfer($sformatf("rnd%0d", i), a, w, d, in_rng(a) ? W + 1 : 1,
                 in_rng(a) ? ref_mem[int'(a)] : 8'hFF);
        end

        // Reset in the middle of a write access
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 24'h000044;
        bus.wb_we_i = 1'b1; bus.wb_dat_i = 8'h77;
        tick();
        bus.wb_stb_i = 1'b0;
        check("rst_mid_we_active", sram_we_n, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_mid_dq_oe", sram_dq_oe, 0);
        check("rst_mid_ack", bus.wb_ack_o, 0);
        bus.wb_cyc_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        prev_dat = 8'h00;
        nack = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.wb_ack_o) nack++;
        end
        check("rst_mid_no_ack", nack, 0);
        xfer("post_reset_read", 24'h001234, 1'b0, 8'h00, W + 1, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
